axis_sa_cfg: RTL and testbench
==============================

# axis_sa_cfg

Runtime-configurable AXI-Stream systolic array (R×C output-stationary MAC grid) that computes the sum of outer products x·kᵀ over one input packet. It drains the R×C result as C output beats of R lanes. It extends the base array with:
- signed/unsigned operand mode
- accumulate-across-packets (K-tiling) and suppressed-output modes
- output requantisation: arithmetic/logical right shift, then saturate or truncate to a narrower output width

It sits between the operand streamers and the output DMA in the accelerator datapath.

## Interface
- R, 4: rows; x lanes; output lanes per beat
- C, 8: columns; k lanes; output beats per result
- WX, 4: x element width
- WK, 8: k element width
- WY, 24: accumulator width; must satisfy WY ≥ WX+WK
- WO, 16: output element width; must satisfy WO ≤ WY
- LM, 1: multiplier pipeline latency, ≥1
- LA, 1: accumulator pipeline latency, ≥1
- WS, $clog2(WY): width of cfg_shift

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- s_valid, s_last  in  1  input handshake / end of packet
- s_ready  out  1  input accept
- sx_data  in  R×WX  x column vector
- sk_data  in  C×WK  k row vector
- cfg_signed  in  1  treat x and k as two's complement
- cfg_accum  in  1  do not clear accumulators at packet start
- cfg_emit  in  1  emit the result of this packet
- cfg_sat  in  1  saturate (1) or truncate to low WO bits (0)
- cfg_shift  in  WS  right-shift amount before narrowing
- m_valid, m_last  out  1  output handshake; m_last marks the final beat
- m_ready  in  1  output accept
- m_data  out  R×WO  one result column

## Operation
- A beat transfers on s_valid && s_ready.
- A packet is N≥1 beats, the last one flagged by s_last.
- All cfg_* inputs are sampled only on a packet's first beat. They are held per packet through the pipeline and ignored on later beats.
- Product: p[r][c] = x[r]·k[c], WX+WK bits; operands are sign-extended when cfg_signed=1, zero-extended otherwise.
- Accumulator at the first valid beat reaching cell (r,c):
  - cfg_accum=0: acc = p
  - cfg_accum=1: acc = acc + p (the previous packet's sum is kept)
- Later beats: acc += p.
- Accumulation wraps modulo 2^WY; no saturation inside the array.
- Beats with s_valid=0 never enter any accumulator.
- cfg_emit=0: the result stays in the accumulators only. No output beats and no output-register occupancy.
- cfg_emit=1: at packet end each cell copies acc into its output register, skewed along the diagonal.
- Output column order is C-1 first down to 0; m_last is on the column-0 beat.
- Output element value:
  - v = acc >>> cfg_shift when signed, acc >> cfg_shift when unsigned.
  - cfg_sat=1: clamp v to [-2^(WO-1), 2^(WO-1)-1] (signed) or [0, 2^WO-1] (unsigned).
  - cfg_sat=0: take v[WO-1:0].
- Packets may be back-to-back. A new packet accumulates while the previous result drains.
- s_ready=0 only when some diagonal must hand off to an output register that is still occupied.
- All pipeline stages stall together with s_ready; no beat, partial sum or result is ever dropped.

## Timing
- Reset values: s_ready=1, m_valid=0, m_last=0, m_data=0. All accumulators, output registers and config holds are 0.
- Reset mid-packet or mid-drain discards all in-flight data. Only the first beat after reset starts a new packet.
- With m_ready=1 and no stall, the first output beat (column C-1) has m_valid=1 no later than LM+LA+R+C+2 cycles after the s_last transfer. The remaining C-1 beats follow on consecutive cycles.
- Sustained throughput is 1 input beat/cycle for packets of ≥C beats with m_ready=1. Shorter packets may incur s_ready gaps.
- Master side follows AXI-Stream:
  - once m_valid=1, m_data/m_last are stable until m_ready=1
  - m_valid never drops without a transfer
- s_ready does not depend combinationally on s_valid.
- An output register frees on the same cycle its beat transfers. A copy into a freed register takes priority on the next cycle.
- Single-beat packets (s_valid && s_last on the first beat) are legal. They clear or accumulate and emit per cfg.
- cfg_shift ≥ WY yields 0 (unsigned) or all sign bits (signed).

## Test plan
Settings: R=2, C=2, WX=4, WK=8, WY=16, WO=8.
- Unsigned, cfg_sat=1, cfg_shift=0: 3 beats x=[1,2], k=[3,4] → beat0=[12,24] (m_last=0), beat1=[9,18] (m_last=1), within the latency bound.
- Signed, 1 beat, x=[4'hF,7], k=[-128,127], cfg_sat=1 → col1=[-127,127], col0=[127,-128]. The same with cfg_sat=0 → col1=[8'h81,8'h79], col0=[8'h80,8'h80].
- K-tiling: packet A (accum=0, emit=0) then packet B (accum=1, emit=1), both 1 beat x=[1,1], k=[2,2] → no output after A; B outputs [4,4],[4,4].
- Shift: unsigned, 1 beat x=15, k=255, cfg_shift=4, cfg_sat=0 → all lanes 8'hEF.
- Backpressure: 6 back-to-back 2-beat packets with m_ready=0 for 60 cycles, then random m_ready → s_ready drops; all 12 output beats match the model in order; m_data stable while stalled.
- Reset: assert rstn=0 mid-packet and mid-drain → next cycle m_valid=0 and s_ready=1; the following packet's result is unaffected by pre-reset data.

Source files
------------

// File: rtl/axis_sa_cfg.sv
// R x C output-stationary MAC array on AXI-Stream. Modes are latched per packet: signed operands,
// K-tiling accumulate, suppressed output. The result is requantised and drained column C-1 first.
module axis_sa_cfg #(
  parameter int unsigned R  = 4,
  parameter int unsigned C  = 8,
  parameter int unsigned WX = 4,
  parameter int unsigned WK = 8,
  parameter int unsigned WY = 24,
  parameter int unsigned WO = 16,
  parameter int unsigned LM = 1,
  parameter int unsigned LA = 1,
  parameter int unsigned WS = $clog2(WY)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  input  logic            s_last,
  output logic            s_ready,
  input  logic [R*WX-1:0] sx_data,
  input  logic [C*WK-1:0] sk_data,
  input  logic            cfg_signed,
  input  logic            cfg_accum,
  input  logic            cfg_emit,
  input  logic            cfg_sat,
  input  logic [WS-1:0]   cfg_shift,
  output logic            m_valid,
  output logic            m_last,
  input  logic            m_ready,
  output logic [R*WO-1:0] m_data
);
  localparam int unsigned WP = WX + WK;
  // LA-1 extra product stages give the same end-to-end latency as a pipelined accumulator
  localparam int unsigned D  = LM + LA - 1;
  localparam int unsigned WC = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned N  = R * C;

  typedef struct packed {
    logic          sgn;
    logic          accum;
    logic          emit;
    logic          sat;
    logic [WS-1:0] shift;
  } cfg_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    cfg_t cfg;
  } tag_t;

  typedef logic [N-1:0][WP-1:0] prod_grid_t;

  logic                   in_pkt_q, in_pkt_d;
  cfg_t                   cfg_hold_q, cfg_hold_d, cfg_in, beat_cfg;
  tag_t                   tag_q [D];
  tag_t                   tag_d [D];
  prod_grid_t             prod_q [D];
  prod_grid_t             prod_d [D];
  prod_grid_t             prod_in;
  logic [N-1:0][WY-1:0]   acc_q, acc_d;
  logic [C-1:0][R*WO-1:0] obank_q, obank_d;
  logic                   ovalid_q, ovalid_d;
  logic [WC-1:0]          col_q, col_d;
  tag_t                   tail;
  logic                   accept, need_copy, bank_free, advance;

  function automatic logic [WP-1:0] mul_ext(input logic [WX-1:0] x, input logic [WK-1:0] k,
                                            input logic sgn);
    logic [WP-1:0] xe, ke;
    xe = sgn ? WP'($signed(x)) : WP'(x);
    ke = sgn ? WP'($signed(k)) : WP'(k);
    return xe * ke;
  endfunction

  function automatic logic [WY-1:0] widen(input logic [WP-1:0] p, input logic sgn);
    return sgn ? WY'($signed(p)) : WY'(p);
  endfunction

  // Saturation check: bits above the output range must be a pure sign (or zero) extension.
  function automatic logic [WO-1:0] requant(input logic [WY-1:0] a, input cfg_t cf);
    logic [WY-1:0] v, hi;
    logic [WO-1:0] smin;
    smin = WO'(1) << (WO - 1);
    if (cf.sgn) begin
      v  = WY'($signed(a) >>> cf.shift);
      hi = WY'($signed(v) >>> (WO - 1));
      if (cf.sat && hi != '0 && hi != '1) return v[WY-1] ? smin : ~smin;
    end else begin
      v  = a >> cf.shift;
      hi = v >> WO;
      if (cf.sat && hi != '0) return '1;
    end
    return v[WO-1:0];
  endfunction

  always_comb begin
    cfg_in.sgn   = cfg_signed;
    cfg_in.accum = cfg_accum;
    cfg_in.emit  = cfg_emit;
    cfg_in.sat   = cfg_sat;
    cfg_in.shift = cfg_shift;
    beat_cfg     = in_pkt_q ? cfg_hold_q : cfg_in;
    tail         = tag_q[D-1];
    need_copy    = tail.valid && tail.last && tail.cfg.emit;
    // the output bank counts as free in the cycle its final beat transfers
    bank_free    = !ovalid_q || (m_ready && col_q == '0);
    advance      = !(need_copy && !bank_free);
    s_ready      = advance;
    accept       = s_valid && advance;
  end

  always_comb begin
    prod_in = '0;
    for (int unsigned r = 0; r < R; r++) begin
      for (int unsigned c = 0; c < C; c++) begin
        prod_in[r*C+c] = mul_ext(sx_data[r*WX +: WX], sk_data[c*WK +: WK], beat_cfg.sgn);
      end
    end
  end

  always_comb begin
    tag_d  = tag_q;
    prod_d = prod_q;
    if (advance) begin
      tag_d[0].valid = accept;
      tag_d[0].first = !in_pkt_q;
      tag_d[0].last  = s_last;
      tag_d[0].cfg   = beat_cfg;
      prod_d[0]      = prod_in;
      for (int unsigned i = 1; i < D; i++) begin
        tag_d[i]  = tag_q[i-1];
        prod_d[i] = prod_q[i-1];
      end
    end
  end

  always_comb begin
    in_pkt_d   = in_pkt_q;
    cfg_hold_d = cfg_hold_q;
    if (accept) begin
      in_pkt_d = !s_last;
      if (!in_pkt_q) cfg_hold_d = cfg_in;
    end
  end

  always_comb begin
    acc_d    = acc_q;
    obank_d  = obank_q;
    ovalid_d = ovalid_q;
    col_d    = col_q;
    if (ovalid_q && m_ready) begin
      if (col_q == '0) ovalid_d = 1'b0;
      else             col_d    = col_q - WC'(1);
    end
    if (advance && tail.valid) begin
      for (int unsigned i = 0; i < N; i++) begin
        acc_d[i] = (tail.first && !tail.cfg.accum) ? widen(prod_q[D-1][i], tail.cfg.sgn)
                                                   : acc_q[i] + widen(prod_q[D-1][i], tail.cfg.sgn);
      end
      if (need_copy) begin
        for (int unsigned r = 0; r < R; r++) begin
          for (int unsigned c = 0; c < C; c++) begin
            obank_d[c][r*WO +: WO] = requant(acc_d[r*C+c], tail.cfg);
          end
        end
        ovalid_d = 1'b1;
        col_d    = WC'(C - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_pkt_q   <= 1'b0;
      cfg_hold_q <= '0;
      acc_q      <= '0;
      obank_q    <= '0;
      ovalid_q   <= 1'b0;
      col_q      <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        tag_q[i]  <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      in_pkt_q   <= in_pkt_d;
      cfg_hold_q <= cfg_hold_d;
      acc_q      <= acc_d;
      obank_q    <= obank_d;
      ovalid_q   <= ovalid_d;
      col_q      <= col_d;
      tag_q      <= tag_d;
      prod_q     <= prod_d;
    end
  end

  assign m_valid = ovalid_q;
  assign m_last  = ovalid_q && (col_q == '0);
  assign m_data  = obank_q[col_q];

endmodule

// File: tb/tb_axis_sa_cfg.sv
// Directed bench for axis_sa_cfg with R=2, C=2, WX=4, WK=8, WY=16, WO=8.
module tb_axis_sa_cfg;
  logic        clk, rstn;
  logic        s_valid, s_last, s_ready;
  logic [7:0]  sx_data;
  logic [15:0] sk_data;
  logic        cfg_signed, cfg_accum, cfg_emit, cfg_sat;
  logic [3:0]  cfg_shift;
  logic        m_valid, m_last, m_ready;
  logic [15:0] m_data;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t       outq[$];
  logic [16:0] expq[$];
  int          macc [2][2];

  axis_sa_cfg #(.R(2), .C(2), .WX(4), .WK(8), .WY(16), .WO(8), .LM(1), .LA(1)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .sx_data(sx_data), .sk_data(sk_data),
    .cfg_signed(cfg_signed), .cfg_accum(cfg_accum), .cfg_emit(cfg_emit),
    .cfg_sat(cfg_sat), .cfg_shift(cfg_shift),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .m_data(m_data)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rstn && m_valid && m_ready) outq.push_back('{data: m_data, last: m_last, cyc: cyc});

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_beats(input int n, input int maxc);
    int i = 0;
    while (outq.size() < n && i < maxc) begin
      step();
      i++;
    end
  endtask

  // Later beats carry inverted cfg values, which the DUT must ignore.
  task automatic send_pkt(input int nb, input logic [7:0] x, input logic [15:0] k,
                          input logic sgn, input logic acc, input logic emit, input logic sat,
                          input logic [3:0] sh, output int t_last);
    int g;
    t_last = 0;
    for (int b = 0; b < nb; b++) begin
      s_valid    = 1'b1;
      s_last     = (b == nb - 1);
      sx_data    = x;
      sk_data    = k;
      cfg_signed = (b == 0) ? sgn : ~sgn;
      cfg_accum  = (b == 0) ? acc : ~acc;
      cfg_emit   = (b == 0) ? emit : ~emit;
      cfg_sat    = (b == 0) ? sat : ~sat;
      cfg_shift  = (b == 0) ? sh : ~sh;
      g = 0;
      @(negedge clk);
      while (!s_ready && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) begin
        tests_run++;
        tests_failed++;
        $display("FAIL s_ready_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, g);
      end
      t_last = cyc + 1;
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic model_pkt(input int nb, input logic [7:0] x, input logic [15:0] k,
                           input bit sgn, input bit accm, input bit emit, input bit sat,
                           input int sh);
    int xv, kv, v;
    logic [3:0] xr;
    logic [7:0] kc;
    int res [2][2];
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        xr = x[r*4 +: 4];
        kc = k[c*8 +: 8];
        xv = sgn ? int'($signed(xr)) : int'(xr);
        kv = sgn ? int'($signed(kc)) : int'(kc);
        macc[r][c] = ((accm ? macc[r][c] : 0) + nb * xv * kv) & 32'hFFFF;
        if (sgn) v = (macc[r][c] >= 32768) ? macc[r][c] - 65536 : macc[r][c];
        else     v = macc[r][c];
        v = v >>> sh;
        if (sat) begin
          if (sgn) begin
            if (v > 127) v = 127;
            else if (v < -128) v = -128;
          end else if (v > 255) v = 255;
        end
        res[r][c] = v & 255;
      end
    end
    if (emit)
      for (int c = 1; c >= 0; c--)
        expq.push_back({(c == 0) ? 1'b1 : 1'b0, 8'(res[1][c]), 8'(res[0][c])});
  endtask

  task automatic test_reset();
    rstn = 0; s_valid = 0; s_last = 0; m_ready = 1;
    sx_data = '0; sk_data = '0;
    cfg_signed = 0; cfg_accum = 0; cfg_emit = 0; cfg_sat = 0; cfg_shift = '0;
    repeat (3) step();
    tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_s_ready: got %b, expected 1", s_ready); end
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid: got %b, expected 0", m_valid); end
    tests_run++; if (m_last !== 1'b0) begin tests_failed++; $display("FAIL reset_m_last: got %b, expected 0", m_last); end
    tests_run++; if (m_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_m_data: got %h, expected 0000", m_data); end
    rstn = 1;
    step();
  endtask

  task automatic test_unsigned_basic();
    int t_last;
    outq.delete();
    m_ready = 1;
    send_pkt(3, 8'h21, 16'h0403, 0, 0, 1, 1, 4'd0, t_last);
    wait_beats(2, 40);
    tests_run++;
    if (outq.size() != 2) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d beats, expected 2", outq.size());
    end else begin
      tests_run++; if (outq[0].data !== 16'h180C) begin tests_failed++; $display("FAIL basic_beat0: got %h, expected 180c", outq[0].data); end
      tests_run++; if (outq[0].last !== 1'b0) begin tests_failed++; $display("FAIL basic_last0: got %b, expected 0", outq[0].last); end
      tests_run++; if (outq[1].data !== 16'h1209) begin tests_failed++; $display("FAIL basic_beat1: got %h, expected 1209", outq[1].data); end
      tests_run++; if (outq[1].last !== 1'b1) begin tests_failed++; $display("FAIL basic_last1: got %b, expected 1", outq[1].last); end
      tests_run++; if (outq[0].cyc - t_last > 8) begin tests_failed++; $display("FAIL basic_latency: got %0d cycles, expected <= 8", outq[0].cyc - t_last); end
      tests_run++; if (outq[1].cyc != outq[0].cyc + 1) begin tests_failed++; $display("FAIL basic_consecutive: got gap %0d, expected 1", outq[1].cyc - outq[0].cyc); end
    end
    repeat (3) step();
  endtask

  task automatic test_signed();
    int t_last;
    logic [15:0] exp0 [2];
    logic [15:0] exp1 [2];
    exp0[0] = 16'h7F81; exp1[0] = 16'h807F;
    exp0[1] = 16'h7981; exp1[1] = 16'h8080;
    for (int s = 0; s < 2; s++) begin
      outq.delete();
      send_pkt(1, 8'h7F, 16'h7F80, 1, 0, 1, (s == 0), 4'd0, t_last);
      wait_beats(2, 40);
      tests_run++;
      if (outq.size() != 2) begin
        tests_failed++;
        $display("FAIL signed_count sat=%0d: got %0d beats, expected 2", s == 0, outq.size());
      end else begin
        tests_run++; if (outq[0].data !== exp0[s]) begin tests_failed++; $display("FAIL signed_col1 sat=%0d: got %h, expected %h", s == 0, outq[0].data, exp0[s]); end
        tests_run++; if (outq[1].data !== exp1[s] || outq[1].last !== 1'b1) begin tests_failed++; $display("FAIL signed_col0 sat=%0d: got %h last %b, expected %h last 1", s == 0, outq[1].data, outq[1].last, exp1[s]); end
      end
      repeat (3) step();
    end
  endtask

  task automatic test_ktile();
    int t_last, seen;
    outq.delete();
    seen = 0;
    send_pkt(1, 8'h11, 16'h0202, 0, 0, 0, 1, 4'd0, t_last);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (m_valid) seen++;
      step();
    end
    tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL ktile_no_emit: got m_valid on %0d cycles, expected 0", seen); end
    send_pkt(1, 8'h11, 16'h0202, 0, 1, 1, 1, 4'd0, t_last);
    wait_beats(2, 40);
    tests_run++;
    if (outq.size() != 2) begin
      tests_failed++;
      $display("FAIL ktile_count: got %0d beats, expected 2", outq.size());
    end else begin
      tests_run++; if (outq[0].data !== 16'h0404) begin tests_failed++; $display("FAIL ktile_beat0: got %h, expected 0404", outq[0].data); end
      tests_run++; if (outq[1].data !== 16'h0404) begin tests_failed++; $display("FAIL ktile_beat1: got %h, expected 0404", outq[1].data); end
    end
    repeat (3) step();
  endtask

  task automatic test_shift();
    int t_last;
    outq.delete();
    send_pkt(1, 8'hFF, 16'hFFFF, 0, 0, 1, 0, 4'd4, t_last);
    wait_beats(2, 40);
    send_pkt(1, 8'hFF, 16'h0180, 1, 0, 1, 0, 4'd15, t_last);
    wait_beats(4, 40);
    tests_run++;
    if (outq.size() != 4) begin
      tests_failed++;
      $display("FAIL shift_count: got %0d beats, expected 4", outq.size());
    end else begin
      tests_run++; if (outq[0].data !== 16'hEFEF || outq[1].data !== 16'hEFEF) begin tests_failed++; $display("FAIL shift_logical: got %h %h, expected efef efef", outq[0].data, outq[1].data); end
      tests_run++; if (outq[2].data !== 16'hFFFF) begin tests_failed++; $display("FAIL shift_arith_neg: got %h, expected ffff", outq[2].data); end
      tests_run++; if (outq[3].data !== 16'h0000) begin tests_failed++; $display("FAIL shift_arith_pos: got %h, expected 0000", outq[3].data); end
    end
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  xs [6];
    logic [15:0] ks [6];
    bit          saw_stall;
    xs = '{8'h21, 8'hF3, 8'h7A, 8'h95, 8'hEE, 8'h0F};
    ks = '{16'h0403, 16'h80FF, 16'h1234, 16'hC07F, 16'hFFFF, 16'h0A55};
    saw_stall = 0;
    outq.delete();
    expq.delete();
    m_ready = 0;
    fork
      begin
        int t_last;
        for (int p = 0; p < 6; p++) begin
          model_pkt(2, xs[p], ks[p], p % 2 == 1, 0, 1, p % 3 == 0, p % 3);
          send_pkt(2, xs[p], ks[p], 1'(p % 2), 0, 1, (p % 3 == 0), 4'(p % 3), t_last);
        end
      end
      begin
        logic [15:0] pd;
        logic        pl, pv;
        pv = 0; pd = '0; pl = 0;
        for (int i = 0; i < 400 && outq.size() < 12; i++) begin
          @(negedge clk);
          if (!s_ready) saw_stall = 1;
          if (pv) begin
            tests_run++;
            if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
              tests_failed++;
              $display("FAIL stall_stable cyc %0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b", cyc, m_valid, m_data, m_last, pd, pl);
            end
          end
          pv = m_valid && !m_ready;
          pd = m_data;
          pl = m_last;
          step();
          m_ready = (i < 60) ? 1'b0 : 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1;
    tests_run++; if (!saw_stall) begin tests_failed++; $display("FAIL bp_stall: got s_ready never low, expected a drop"); end
    tests_run++;
    if (outq.size() != 12 || expq.size() != 12) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d beats, expected %0d", outq.size(), expq.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        tests_run++;
        if (outq[i].data !== expq[i][15:0] || outq[i].last !== expq[i][16]) begin
          tests_failed++;
          $display("FAIL bp_beat%0d: got %h last %b, expected %h last %b", i, outq[i].data, outq[i].last, expq[i][15:0], expq[i][16]);
        end
      end
    end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    int t_last, g;
    // mid-packet: first beat of a packet whose held cfg suppresses output
    s_valid = 1; s_last = 0; sx_data = 8'h33; sk_data = 16'h0505;
    cfg_signed = 0; cfg_accum = 1; cfg_emit = 0; cfg_sat = 0; cfg_shift = '0;
    @(negedge clk);
    step();
    s_valid = 0;
    rstn = 0;
    step();
    tests_run++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_pkt: got m_valid=%b s_ready=%b, expected 0 1", m_valid, s_ready); end
    rstn = 1;
    step();
    // mid-drain
    m_ready = 0;
    send_pkt(1, 8'h11, 16'h0101, 0, 0, 1, 1, 4'd0, t_last);
    g = 0;
    while (!m_valid && g < 20) begin step(); g++; end
    tests_run++; if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_drain_setup: got m_valid=%b, expected 1", m_valid); end
    rstn = 0;
    step();
    tests_run++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_last !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_drain: got m_valid=%b s_ready=%b m_last=%b, expected 0 1 0", m_valid, s_ready, m_last); end
    tests_run++; if (m_data !== 16'h0000) begin tests_failed++; $display("FAIL rst_m_data: got %h, expected 0000", m_data); end
    rstn = 1;
    m_ready = 1;
    step();
    outq.delete();
    send_pkt(1, 8'h11, 16'h0101, 0, 1, 1, 1, 4'd0, t_last);
    wait_beats(2, 40);
    tests_run++;
    if (outq.size() != 2) begin
      tests_failed++;
      $display("FAIL rst_post_count: got %0d beats, expected 2", outq.size());
    end else begin
      tests_run++; if (outq[0].data !== 16'h0101 || outq[1].data !== 16'h0101 || outq[1].last !== 1'b1) begin tests_failed++; $display("FAIL rst_post_data: got %h %h last %b, expected 0101 0101 last 1", outq[0].data, outq[1].data, outq[1].last); end
    end
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_ktile();
    test_shift();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
